// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider: op encodings, FSM states, constants.
// Optional feature macro used by the divider: SEQ_DIVIDER_FAST_SPECIAL_EN.
package div_pkg;

    localparam int DIV_XLEN = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    localparam logic [DIV_XLEN-1:0] DIV_MOST_NEG = {1'b1, {(DIV_XLEN-1){1'b0}}};
    localparam logic [DIV_XLEN-1:0] DIV_ALL_ONES = {DIV_XLEN{1'b1}};

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract the divisor.
import div_pkg::*;

module div_step #(
    parameter int XLEN = DIV_XLEN
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    // The top bit of the XLEN+1-bit difference is the borrow: clear means the divisor fits.
    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        fits    = ~diff[XLEN];
        rem_out = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_out = {quo_in[XLEN-2:0], fits};
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with valid/ready handshakes.
// SEQ_DIVIDER_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip CALC/FIX and finish at accept.
import div_pkg::*;

module seq_divider #(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MOST_NEG = DIV_MOST_NEG;
    localparam logic [XLEN-1:0] ALL_ONES = DIV_ALL_ONES;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    div_state_t state;
    div_state_t state_next;

    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  dvs;
    logic [1:0]       op_q;
    logic             q_neg;
    logic             r_neg;
    logic             div_zero;
    logic             ovf;

    logic             accept;
    logic             in_signed;
    logic             in_div_zero;
    logic             in_ovf;
    logic [XLEN-1:0]  mag_dividend;
    logic [XLEN-1:0]  mag_divisor;

    logic [XLEN-1:0]  step_rem;
    logic [XLEN-1:0]  step_quo;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;
    logic [XLEN-1:0]  fix_result;

`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
    logic             in_special;
    logic [XLEN-1:0]  special_result;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dvs),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Accept-side decode: operand magnitudes and special-case detection.
    always_comb begin
        accept       = in_valid && (state == IDLE) && !flush;
        in_signed    = op_is_signed(op);
        in_div_zero  = (divisor == '0);
        in_ovf       = in_signed && (dividend == MOST_NEG) && (divisor == ALL_ONES);
        mag_dividend = (in_signed && dividend[XLEN-1]) ? -dividend : dividend;
        mag_divisor  = (in_signed && divisor[XLEN-1])  ? -divisor  : divisor;
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
        in_special     = in_div_zero || in_ovf;
        special_result = '0;
        if (in_div_zero) begin
            special_result = op_is_rem(op) ? dividend : ALL_ONES;
        end else if (in_ovf) begin
            special_result = op_is_rem(op) ? '0 : MOST_NEG;
        end
`endif
    end

    // Sign fix-up and special-case substitution. With a zero divisor every trial subtract
    // succeeds, so the sign-corrected remainder already equals the original dividend.
    always_comb begin
        quo_fix    = q_neg ? -quo : quo;
        rem_fix    = r_neg ? -rem : rem;
        fix_result = op_is_rem(op_q) ? rem_fix : quo_fix;
        if (div_zero) begin
            fix_result = op_is_rem(op_q) ? rem_fix : ALL_ONES;
        end else if (ovf) begin
            fix_result = op_is_rem(op_q) ? '0 : MOST_NEG;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
                    state_next = in_special ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = flush ? IDLE : DONE;
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            op_q     <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            result   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= op;
                        cnt      <= '0;
                        rem      <= '0;
                        quo      <= mag_dividend;
                        dvs      <= mag_divisor;
                        q_neg    <= in_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        r_neg    <= in_signed && dividend[XLEN-1];
                        div_zero <= in_div_zero;
                        ovf      <= in_ovf;
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
                        if (in_special) begin
                            result <= special_result;
                        end
`endif
                    end
                end
                CALC: begin
                    if (!flush) begin
                        rem <= step_rem;
                        quo <= step_quo;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        result <= fix_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: arithmetic, special cases, latency, backpressure, flush, reset.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam int NORMAL_LAT = 34;
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 34;
`endif

    seq_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, measure edges from accept (inclusive) to out_valid, optionally stall, then handshake.
    task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_res,
                                 input int exp_lat, input int hold);
        int waits;
        int lat;
        waits = 0;
        while (!in_ready && waits < 100) begin
            @(posedge clk); #1;
            waits++;
        end
        op       = o;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_res"}, result, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            checkOutput({tag, "_hold_res"}, result, exp_res);
            checkOutput({tag, "_hold_ready"}, {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_vdrop"}, {31'b0, out_valid}, 32'd0);
        checkOutput({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        dividend  = '0;
        divisor   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, NORMAL_LAT, 0);
        applyStimulus("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, NORMAL_LAT, 0);
        applyStimulus("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORMAL_LAT, 0);
        applyStimulus("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORMAL_LAT, 0);
        applyStimulus("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, NORMAL_LAT, 0);
        applyStimulus("div_20_m3", OP_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, NORMAL_LAT, 0);
        applyStimulus("rem_20_m3", OP_REM, 32'd20, 32'hFFFF_FFFD, 32'd2, NORMAL_LAT, 0);

        applyStimulus("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT, 0);
        applyStimulus("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, SPECIAL_LAT, 0);
        applyStimulus("rem_m7_0", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SPECIAL_LAT, 0);
        applyStimulus("divu_min_0", OP_DIVU, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT, 0);
        applyStimulus("remu_min_0", OP_REMU, 32'h8000_0000, 32'd0, 32'h8000_0000, SPECIAL_LAT, 0);
        applyStimulus("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT, 0);
        applyStimulus("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_LAT, 0);
        applyStimulus("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, NORMAL_LAT, 0);

        applyStimulus("divu_bp", OP_DIVU, 32'd100, 32'd7, 32'd14, NORMAL_LAT, 5);

        // Flush while CALC is on iteration 10; the op must vanish without out_valid.
        op       = OP_DIVU;
        dividend = 32'd100;
        divisor  = 32'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        checkOutput("flush_no_valid", 32'(seen), 32'd0);

        // Reset mid-CALC, then a fresh request and a back-to-back follower.
        op       = OP_DIVU;
        dividend = 32'd1000;
        divisor  = 32'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midreset_result", result, 32'd0);

        applyStimulus("divu_ff_16", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, NORMAL_LAT, 0);
        checkOutput("b2b_in_ready", {31'b0, in_ready}, 32'd1);
        applyStimulus("b2b_divu", OP_DIVU, 32'd1000, 32'd10, 32'd100, NORMAL_LAT, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
